// File: rtl/ov7670_capture.sv
// OV7670 DVP capture: waits for camera configuration, locks onto VSYNC/HREF framing
// and assembles byte pairs into a valid-qualified RGB565 stream with sticky error status.
`timescale 1ns/1ps
module ov7670_capture #(
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int SKIP_FRAMES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        config_done,
   input  logic        vsync,
   input  logic        href,
   input  logic [7:0]  d,
   output logic [15:0] pixel_data,
   output logic        pixel_valid,
   output logic        sof,
   output logic        eol,
   output logic        frame_done,
   output logic [7:0]  frame_cnt,
   output logic        err_odd,
   output logic        err_size
);

   localparam int XW = $clog2(H_ACTIVE + 2);
   localparam int YW = $clog2(V_ACTIVE + 2);
   localparam logic [XW-1:0] X_END  = XW'(H_ACTIVE);
   localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
   localparam logic [XW-1:0] X_SAT  = XW'(H_ACTIVE + 1);
   localparam logic [YW-1:0] Y_END  = YW'(V_ACTIVE);
   localparam logic [YW-1:0] Y_SAT  = YW'(V_ACTIVE + 1);

   typedef enum logic [1:0] {WAIT_CFG, SYNC, BLANK, ACTIVE} state_t;

   state_t        state_q, state_d;
   logic          vsync_r_q, href_r_q, vsync_p_q, href_p_q;
   logic [7:0]    d_r_q;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d, y_line;
   logic          phase_q, phase_d;
   logic [7:0]    hi_byte_q, hi_byte_d;
   logic [3:0]    skip_q, skip_d;
   logic          skipping_q, skipping_d;
   logic [15:0]   pixel_data_q, pixel_data_d;
   logic          pixel_valid_q, pixel_valid_d;
   logic          sof_q, sof_d, eol_q, eol_d;
   logic          frame_done_q, frame_done_d;
   logic [7:0]    frame_cnt_q, frame_cnt_d;
   logic          err_odd_q, err_odd_d, err_size_q, err_size_d;
   logic          vs_rise, vs_fall, hr_fall;

   assign vs_rise = vsync_r_q & ~vsync_p_q;
   assign vs_fall = ~vsync_r_q & vsync_p_q;
   assign hr_fall = ~href_r_q & href_p_q;

   always_comb begin
      // NOTE: every target gets a default before any branch so no latch is inferred.
      state_d       = state_q;
      x_d           = x_q;
      y_d           = y_q;
      y_line        = y_q;
      phase_d       = phase_q;
      hi_byte_d     = hi_byte_q;
      skip_d        = skip_q;
      skipping_d    = skipping_q;
      pixel_data_d  = pixel_data_q;
      pixel_valid_d = 1'b0;
      sof_d         = 1'b0;
      eol_d         = 1'b0;
      frame_done_d  = 1'b0;
      frame_cnt_d   = frame_cnt_q;
      err_odd_d     = err_odd_q;
      err_size_d    = err_size_q;

      if (!config_done) begin
         state_d = WAIT_CFG;
         x_d     = '0;
         y_d     = '0;
         phase_d = 1'b0;
         skip_d  = '0;
      end else begin
         case (state_q)
            WAIT_CFG: begin
               state_d = SYNC;
               skip_d  = 4'(SKIP_FRAMES);
            end
            SYNC: if (vs_rise) state_d = BLANK;
            BLANK: if (vs_fall) begin
               state_d    = ACTIVE;
               skipping_d = (skip_q != '0);
               x_d        = '0;
               y_d        = '0;
               phase_d    = 1'b0;
            end
            ACTIVE: begin
               if (href_r_q) begin
                  phase_d = ~phase_q;
                  if (!phase_q) begin
                     hi_byte_d = d_r_q;
                  end else begin
                     if (x_q < X_END && y_q < Y_END) begin
                        if (!skipping_q) begin
                           pixel_data_d  = {hi_byte_q, d_r_q};
                           pixel_valid_d = 1'b1;
                           sof_d         = (x_q == '0) && (y_q == '0);
                           eol_d         = (x_q == X_LAST);
                        end
                     end else begin
                        err_size_d = 1'b1;
                     end
                     if (x_q != X_SAT) x_d = x_q + 1'b1;
                  end
               end else if (hr_fall) begin
                  if (phase_q) err_odd_d = 1'b1;
                  if (x_q != X_END) err_size_d = 1'b1;
                  if (x_q != '0 && y_q != Y_SAT) y_line = y_q + 1'b1;
                  y_d     = y_line;
                  x_d     = '0;
                  phase_d = 1'b0;
               end
               // Frame end sees the line count already bumped by a coincident line end.
               if (vs_rise) begin
                  if (y_line != Y_END) err_size_d = 1'b1;
                  if (!skipping_q) begin
                     frame_done_d = 1'b1;
                     frame_cnt_d  = frame_cnt_q + 8'd1;
                  end
                  if (skip_q != '0) skip_d = skip_q - 4'd1;
                  x_d     = '0;
                  y_d     = '0;
                  phase_d = 1'b0;
                  state_d = BLANK;
               end
            end
            default: state_d = WAIT_CFG;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q       <= WAIT_CFG;
         vsync_r_q     <= 1'b0;
         href_r_q      <= 1'b0;
         vsync_p_q     <= 1'b0;
         href_p_q      <= 1'b0;
         d_r_q         <= '0;
         x_q           <= '0;
         y_q           <= '0;
         phase_q       <= 1'b0;
         hi_byte_q     <= '0;
         skip_q        <= '0;
         skipping_q    <= 1'b0;
         pixel_data_q  <= '0;
         pixel_valid_q <= 1'b0;
         sof_q         <= 1'b0;
         eol_q         <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_cnt_q   <= '0;
         err_odd_q     <= 1'b0;
         err_size_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         vsync_r_q     <= vsync;
         href_r_q      <= href;
         vsync_p_q     <= vsync_r_q;
         href_p_q      <= href_r_q;
         d_r_q         <= d;
         x_q           <= x_d;
         y_q           <= y_d;
         phase_q       <= phase_d;
         hi_byte_q     <= hi_byte_d;
         skip_q        <= skip_d;
         skipping_q    <= skipping_d;
         pixel_data_q  <= pixel_data_d;
         pixel_valid_q <= pixel_valid_d;
         sof_q         <= sof_d;
         eol_q         <= eol_d;
         frame_done_q  <= frame_done_d;
         frame_cnt_q   <= frame_cnt_d;
         err_odd_q     <= err_odd_d;
         err_size_q    <= err_size_d;
      end
   end

   assign pixel_data  = pixel_data_q;
   assign pixel_valid = pixel_valid_q;
   assign sof         = sof_q;
   assign eol         = eol_q;
   assign frame_done  = frame_done_q;
   assign frame_cnt   = frame_cnt_q;
   assign err_odd     = err_odd_q;
   assign err_size    = err_size_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// Scoreboard bench for ov7670_capture: small 4x2 frames, skip handling, error flags,
// config_done loss and frame counter wrap (second instance without skip frames).
`timescale 1ns/1ps
module tb_ov7670_capture;
   localparam int H = 4;
   localparam int V = 2;

   logic        clk = 1'b0;
   logic        rst, config_done, vsync, href;
   logic [7:0]  d;
   logic [15:0] pixel_data, pixel_data0;
   logic        pixel_valid, sof, eol, frame_done, err_odd, err_size;
   logic        pixel_valid0, sof0, eol0, frame_done0, err_odd0, err_size0;
   logic [7:0]  frame_cnt, frame_cnt0;

   always #5 clk = ~clk;

   ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(1)) u_dut (
      .clk(clk), .rst(rst), .config_done(config_done), .vsync(vsync), .href(href), .d(d),
      .pixel_data(pixel_data), .pixel_valid(pixel_valid), .sof(sof), .eol(eol),
      .frame_done(frame_done), .frame_cnt(frame_cnt), .err_odd(err_odd), .err_size(err_size));

   ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(0)) u_dut0 (
      .clk(clk), .rst(rst), .config_done(config_done), .vsync(vsync), .href(href), .d(d),
      .pixel_data(pixel_data0), .pixel_valid(pixel_valid0), .sof(sof0), .eol(eol0),
      .frame_done(frame_done0), .frame_cnt(frame_cnt0), .err_odd(err_odd0), .err_size(err_size0));

   typedef struct packed {
      logic [15:0] data;
      logic        sof;
      logic        eol;
      logic [31:0] cyc;
   } pix_t;

   pix_t        sb_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] cyc      = 0;
   int          fd_cnt   = 0;
   int          fd0_cnt  = 0;
   logic        prev_valid = 1'b0;
   logic [7:0]  exp_cnt;
   int          fd_base, fd0_base;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 32'd1;

   // Output monitor: every pixel must match the head of the scoreboard, in the right cycle.
   always @(negedge clk) begin
      if (pixel_valid) begin
         check("pix_spacing", 32'(prev_valid), 32'd0);
         if (sb_q.size() == 0) begin
            check("pix_extra", 32'(pixel_valid), 32'd0);
         end else begin
            check("pix_data", 32'(pixel_data), 32'(sb_q[0].data));
            check("pix_sof", 32'(sof), 32'(sb_q[0].sof));
            check("pix_eol", 32'(eol), 32'(sb_q[0].eol));
            check("pix_cycle", cyc, sb_q[0].cyc);
            void'(sb_q.pop_front());
         end
      end else if (sof || eol) begin
         check("marker_without_valid", 32'({sof, eol}), 32'd0);
      end
      prev_valid <= pixel_valid;
      if (frame_done)  fd_cnt  <= fd_cnt + 1;
      if (frame_done0) fd0_cnt <= fd0_cnt + 1;
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         href = 1'b0;
      end
   endtask

   // drop_at: byte index at which config_done is pulled low together with that byte (-1: never).
   task automatic send_line(input int nbytes, input logic [7:0] base, input bit emit,
                            input int y, input int drop_at);
      logic [7:0] hi;
      hi = '0;
      for (int i = 0; i < nbytes; i++) begin
         @(negedge clk);
         href = 1'b1;
         d    = base + 8'(i);
         if (i == drop_at) config_done = 1'b0;
         if (i % 2 == 0) begin
            hi = d;
         end else if (emit && (i / 2) < H && y < V && (drop_at < 0 || drop_at >= i + 2)) begin
            sb_q.push_back('{data: {hi, d}, sof: (i / 2 == 0 && y == 0),
                             eol: (i / 2 == H - 1), cyc: cyc + 32'd2});
         end
      end
      @(negedge clk);
      href = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_frame(input int lines, input bit emit);
      for (int y = 0; y < lines; y++) send_line(2 * H, 8'(y * 2 * H), emit, y, -1);
   endtask

   task automatic vsync_pulse(input bit exp_done);
      @(negedge clk);
      href  = 1'b0;
      vsync = 1'b1;
      repeat (2) @(negedge clk);
      check("frame_done", 32'(frame_done), 32'(exp_done));
      if (exp_done) exp_cnt++;
      check("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
      repeat (2) @(negedge clk);
      vsync = 1'b0;
      idle(3);
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst     = 1'b0;
      exp_cnt = '0;
      idle(2);
   endtask

   task automatic relock();
      reset_pulse();
      vsync_pulse(1'b0);
      send_frame(V, 1'b0);
      vsync_pulse(1'b0);
      check("relock_err_odd", 32'(err_odd), 32'd0);
      check("relock_err_size", 32'(err_size), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; config_done = 1'b1; vsync = 1'b0; href = 1'b0; d = '0; exp_cnt = '0;
      repeat (3) @(negedge clk);
      check("rst_pixel_data", 32'(pixel_data), 32'd0);
      check("rst_pixel_valid", 32'(pixel_valid), 32'd0);
      check("rst_sof", 32'(sof), 32'd0);
      check("rst_eol", 32'(eol), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      check("rst_err_odd", 32'(err_odd), 32'd0);
      check("rst_err_size", 32'(err_size), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      idle(2);

      // Three clean frames: first skipped, next two emitted.
      vsync_pulse(1'b0);
      send_frame(V, 1'b0);
      vsync_pulse(1'b0);
      send_frame(V, 1'b1);
      vsync_pulse(1'b1);
      send_frame(V, 1'b1);
      vsync_pulse(1'b1);
      check("clean_drain", 32'(sb_q.size()), 32'd0);
      check("clean_err_odd", 32'(err_odd), 32'd0);
      check("clean_err_size", 32'(err_size), 32'd0);

      // Configuration not done, then raised mid-frame.
      @(negedge clk);
      config_done = 1'b0;
      vsync_pulse(1'b0);
      send_frame(V, 1'b0);
      vsync_pulse(1'b0);
      send_line(2 * H, 8'h00, 1'b0, 0, -1);
      config_done = 1'b1;
      send_line(2 * H, 8'h08, 1'b0, 1, -1);
      vsync_pulse(1'b0);
      send_frame(V, 1'b0);
      vsync_pulse(1'b0);
      send_frame(V, 1'b1);
      vsync_pulse(1'b1);

      // Odd-length line: lone byte dropped, width still correct.
      send_line(2 * H + 1, 8'h00, 1'b1, 0, -1);
      send_line(2 * H, 8'h08, 1'b1, 1, -1);
      vsync_pulse(1'b1);
      check("odd_err_odd", 32'(err_odd), 32'd1);
      check("odd_err_size", 32'(err_size), 32'd0);
      send_frame(V, 1'b1);
      vsync_pulse(1'b1);
      check("odd_sticky", 32'(err_odd), 32'd1);
      check("odd_err_size_kept", 32'(err_size), 32'd0);

      // Over-long line.
      send_line(2 * H + 4, 8'h00, 1'b1, 0, -1);
      send_line(2 * H, 8'h08, 1'b1, 1, -1);
      vsync_pulse(1'b1);
      check("long_line_err_size", 32'(err_size), 32'd1);

      // Short frame, then tall frame, each from a fresh reset.
      relock();
      send_frame(V - 1, 1'b1);
      vsync_pulse(1'b1);
      check("short_frame_err_size", 32'(err_size), 32'd1);
      check("short_frame_err_odd", 32'(err_odd), 32'd0);
      relock();
      send_frame(V + 1, 1'b1);
      vsync_pulse(1'b1);
      check("tall_frame_err_size", 32'(err_size), 32'd1);

      // config_done lost during the second line of an output frame.
      relock();
      send_line(2 * H, 8'h00, 1'b1, 0, -1);
      send_line(2 * H, 8'h08, 1'b1, 1, 4);
      idle(2);
      check("drop_drain", 32'(sb_q.size()), 32'd0);
      config_done = 1'b1;
      vsync_pulse(1'b0);
      send_frame(V, 1'b0);
      vsync_pulse(1'b0);
      send_frame(V, 1'b1);
      vsync_pulse(1'b1);

      // Frame counter wrap: 257 output frames on the no-skip instance.
      reset_pulse();
      fd_base  = fd_cnt;
      fd0_base = fd0_cnt;
      vsync_pulse(1'b0);
      send_frame(V, 1'b0);
      vsync_pulse(1'b0);
      repeat (256) begin
         send_frame(V, 1'b1);
         vsync_pulse(1'b1);
      end
      idle(4);
      check("wrap_fd0_count", 32'(fd0_cnt - fd0_base), 32'd257);
      check("wrap_frame_cnt0", 32'(frame_cnt0), 32'd1);
      check("wrap_fd_count", 32'(fd_cnt - fd_base), 32'd256);

      idle(5);
      check("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
